// File: rtl/json_hw_pkg.sv
// json_hw_pkg: shared types and codes for the JSON decode hardware
package json_hw_pkg;
  localparam int ERR_KIND_W = 4;
  localparam int IDX_MAX_W = 32;
  localparam logic [ERR_KIND_W-1:0] ERR_NONE = 4'h0;
  localparam logic [ERR_KIND_W-1:0] ERR_UNEXPECTED_CHAR = 4'h1;
  localparam logic [ERR_KIND_W-1:0] ERR_UNEXPECTED_END = 4'h2;
  localparam logic [ERR_KIND_W-1:0] ERR_BAD_NUMBER = 4'h3;
  localparam logic [ERR_KIND_W-1:0] ERR_BAD_STRING = 4'h4;
  localparam logic [ERR_KIND_W-1:0] ERR_BAD_ESCAPE = 4'h5;
  localparam logic [ERR_KIND_W-1:0] ERR_DEPTH = 4'h6;
  localparam logic [ERR_KIND_W-1:0] ERR_TRAILING = 4'h7;
  localparam logic [ERR_KIND_W-1:0] ERR_ARB_TIMEOUT = 4'hF;
  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, WAIT_RSP, RSP} arb_state_t;
  typedef struct packed {
    logic ok;
    logic [ERR_KIND_W-1:0] kind;
    logic [IDX_MAX_W-1:0] idx;
  } dec_result_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after ptr
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any
);
  localparam int W = $clog2(N);
  // scan from farthest to nearest so the nearest requester overwrites
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[W'((int'(ptr) + k) % N)]) grant = W'((int'(ptr) + k) % N);
    end
  end
  assign any = |req;
endmodule

// File: rtl/json_decode_arbiter.sv
// json_decode_arbiter: round-robin document-level sharing of one JSON decoder
module json_decode_arbiter
  import json_hw_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*8-1:0]    req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [7:0]            dec_data,
  output logic                  dec_last,
  output logic                  dec_abort,
  input  logic                  dec_done,
  input  logic                  dec_ok,
  input  logic [ERR_KIND_W-1:0] dec_err_kind,
  input  logic [IDX_W-1:0]      dec_err_idx,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic                  rsp_ok,
  output logic [ERR_KIND_W-1:0] rsp_err_kind,
  output logic [IDX_W-1:0]      rsp_err_idx,
  output logic                  busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);
  arb_state_t state, nxt;
  logic [PW-1:0] owner, rr_ptr, pick;
  logic [CW-1:0] cnt;
  logic any, xfer, last_xfer, timeout, take_done;
  dec_result_t res;
  rr_picker #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(pick),
    .any  (any)
  );
  assign xfer = state == STREAM && req_valid[owner] && dec_ready;
  assign last_xfer = xfer && req_last[owner];
  assign take_done = dec_done && (state == STREAM || state == WAIT_RSP);
  assign timeout = state == WAIT_RSP && cnt == CNT_MAX && !dec_done;
  // owner's stream passes through in STREAM, is swallowed in DRAIN; result shown only in RSP
  always_comb begin
    req_ready = '0;
    req_ready[owner] = (state == STREAM && dec_ready) || state == DRAIN;
    rsp_valid = '0;
    rsp_valid[owner] = state == RSP;
    dec_valid = state == STREAM && req_valid[owner];
    dec_data = state == STREAM ? req_data[owner*8 +: 8] : '0;
    dec_last = state == STREAM && req_last[owner];
    dec_abort = timeout;
    rsp_ok = state == RSP && res.ok;
    rsp_err_kind = state == RSP ? res.kind : '0;
    rsp_err_idx = state == RSP ? res.idx[IDX_W-1:0] : '0;
    busy = state != IDLE;
  end
  // next-state: an early decoder result diverts to DRAIN unless the last byte goes this cycle
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = any ? STREAM : IDLE;
      STREAM:   nxt = dec_done ? (last_xfer ? RSP : DRAIN) : (last_xfer ? WAIT_RSP : STREAM);
      DRAIN:    nxt = req_valid[owner] && req_last[owner] ? RSP : DRAIN;
      WAIT_RSP: nxt = dec_done || timeout ? RSP : WAIT_RSP;
      RSP:      nxt = rsp_ready[owner] ? IDLE : RSP;
      default:  nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // grant owner, rotate pointer past the finished owner, time the result, latch it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      if (state == IDLE && any) owner <= pick;
      if (state == RSP && rsp_ready[owner]) rr_ptr <= owner == LAST_REQ ? '0 : owner + 1'b1;
      cnt <= last_xfer ? '0 : state == WAIT_RSP ? cnt + 1'b1 : cnt;
      if (take_done) res <= '{ok: dec_ok, kind: dec_err_kind, idx: IDX_MAX_W'(dec_err_idx)};
      else if (timeout) res <= '{ok: 1'b0, kind: ERR_ARB_TIMEOUT, idx: '1};
    end
  end
endmodule

// File: tb/tb_json_decode_arbiter.sv
// tb_json_decode_arbiter: scoreboard bench with requester sources and a decoder model
module tb_json_decode_arbiter;
  import json_hw_pkg::*;
  localparam int N = 4;
  typedef struct packed {
    logic [1:0]  r;
    logic        ok;
    logic [3:0]  kind;
    logic [15:0] idx;
  } rsp_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready, req_last = '0, rsp_valid, rsp_ready = '1;
  logic [N*8-1:0] req_data = '0;
  logic dec_valid, dec_ready = 1, dec_last, dec_abort, dec_done = 0, dec_ok = 0, rsp_ok, busy;
  logic [7:0] dec_data;
  logic [ERR_KIND_W-1:0] dec_err_kind = '0, rsp_err_kind;
  logic [15:0] dec_err_idx = '0, rsp_err_idx;
  logic [8:0] src_q [N][$];
  logic [10:0] exp_dec [$];
  rsp_t exp_rsp [$];
  int n_chk = 0, n_pass = 0;
  int dcnt = 0, done_cd = 0, done_idx = 0, err_after = 0, sl = 100, abort_cnt = 0, dmode = 0;
  bit dtog = 0;
  logic [N-1:0] hs;
  logic dhs, dlast, dabort;

  json_decode_arbiter #(.N_REQ(N), .IDX_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data), .dec_last(dec_last),
    .dec_abort(dec_abort), .dec_done(dec_done), .dec_ok(dec_ok),
    .dec_err_kind(dec_err_kind), .dec_err_idx(dec_err_idx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
    .rsp_err_kind(rsp_err_kind), .rsp_err_idx(rsp_err_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_doc(int r, string s, int nfwd);
    for (int k = 0; k < s.len(); k++) begin
      src_q[r].push_back({k == s.len() - 1, s[k]});
      if (k < nfwd) exp_dec.push_back({2'(r), k == s.len() - 1, s[k]});
    end
  endtask

  task automatic expect_rsp(int r, logic ok, logic [3:0] kind, logic [15:0] idx);
    exp_rsp.push_back('{2'(r), ok, kind, idx});
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1;
    return 0;
  endfunction

  task automatic tick();
    rsp_t e;
    logic [10:0] d;
    bit fire;
    @(negedge clk);
    hs = req_valid & req_ready;
    dhs = dec_valid && dec_ready;
    dlast = dec_last;
    dabort = dec_abort;
    check("rdy_onehot", 32'($onehot0(req_ready)), 1);
    if (dhs) begin
      check("dec_q", 32'(exp_dec.size() != 0), 1);
      if (exp_dec.size() != 0) begin
        d = exp_dec.pop_front();
        check("dec_byte", {dec_last, dec_data}, d[8:0]);
        check("req_ready", req_ready, 4'b1 << d[10:9]);
      end
    end
    if (dhs && dec_last) sl = 0;
    else sl++;
    if (dec_abort) begin
      abort_cnt++;
      check("abort_lat", sl, 8);
    end
    if (rsp_valid != 0) begin
      check("rsp_q", 32'(exp_rsp.size() != 0), 1);
      if (exp_rsp.size() != 0) begin
        e = exp_rsp.pop_front();
        check("rsp_valid", rsp_valid, 4'b1 << e.r);
        check("rsp_fields", {rsp_ok, rsp_err_kind, rsp_err_idx}, {e.ok, e.kind, e.idx});
      end
    end else check("rsp_idle", {rsp_ok, rsp_err_kind, rsp_err_idx}, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
    dec_done = 0;
    fire = 0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        dec_done = 1;
        dec_ok = 1;
        dec_err_kind = ERR_NONE;
        dec_err_idx = 16'(done_idx);
      end
    end
    if (dabort) dcnt = 0;
    if (dhs) begin
      dcnt++;
      if (dmode == 1 && dcnt == err_after) begin
        dec_done = 1;
        dec_ok = 0;
        dec_err_kind = ERR_BAD_NUMBER;
        dec_err_idx = 16'd2;
        dcnt = 0;
        fire = 1;
      end else if (dlast) begin
        if (dmode == 0) begin
          done_cd = 1;
          done_idx = dcnt;
        end
        dcnt = 0;
      end
    end
    dec_ready = fire ? 1'b0 : dtog ? ~dec_ready : 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = src_q[i].size() != 0;
      req_data[i*8 +: 8] = req_valid[i] ? src_q[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] && src_q[i][0][8];
    end
  endtask

  task automatic drain(int budget);
    int c = 0;
    while ((busy || exp_rsp.size() != 0 || src_pending()) && c < budget) begin
      tick();
      c++;
    end
    check("budget", 32'(c < budget), 1);
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {req_ready, dec_valid, dec_last, dec_abort, rsp_valid, busy}, 0);
    check("rst_dat", {dec_data, rsp_ok, rsp_err_kind, rsp_err_idx}, 0);
    rst = 0;
    dec_done = 1;
    dec_ok = 0;
    dec_err_kind = 4'h5;
    dec_err_idx = 16'h1234;
    repeat (3) tick();
    send_doc(0, "ab", 2);
    send_doc(2, "cd", 2);
    send_doc(3, "ef", 2);
    expect_rsp(0, 1, 0, 2);
    expect_rsp(2, 1, 0, 2);
    expect_rsp(3, 1, 0, 2);
    drain(300);
    send_doc(0, "[1]", 3);
    expect_rsp(0, 1, 0, 3);
    drain(200);
    send_doc(1, "7", 1);
    send_doc(0, "8", 1);
    expect_rsp(1, 1, 0, 1);
    expect_rsp(0, 1, 0, 1);
    drain(200);
    dmode = 1;
    err_after = 3;
    send_doc(1, "[12,34", 3);
    expect_rsp(1, 0, 4'h3, 16'd2);
    drain(200);
    dmode = 2;
    send_doc(0, "{}", 2);
    expect_rsp(0, 0, 4'hF, 16'hFFFF);
    drain(200);
    dmode = 0;
    check("abort_cnt", abort_cnt, 1);
    dtog = 1;
    send_doc(2, "true", 4);
    expect_rsp(2, 1, 0, 4);
    drain(200);
    dtog = 0;
    send_doc(0, "12345", 2);
    c = 0;
    while (dcnt < 2 && c < 50) begin
      tick();
      c++;
    end
    check("mid_budget", 32'(c < 50), 1);
    #2 rst = 1;
    #1;
    check("mid_rst_ctl", {req_ready, dec_valid, dec_last, dec_abort, rsp_valid, busy}, 0);
    check("mid_rst_dat", {dec_data, rsp_ok, rsp_err_kind, rsp_err_idx}, 0);
    src_q[0].delete();
    exp_dec.delete();
    exp_rsp.delete();
    dcnt = 0;
    repeat (2) tick();
    rst = 0;
    send_doc(3, "ok", 2);
    expect_rsp(3, 1, 0, 2);
    drain(200);
    check("abort_total", abort_cnt, 1);
    check("dec_left", exp_dec.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/json_decode_arbiter.md
Name: json_decode_arbiter

Overview:
- Shares one streaming JSON decoder core between N_REQ byte-stream requesters.
- Grants one whole document at a time, round-robin, and locks the grant until the requester's last byte.
- Routes the decoder's ok/error result (kind, byte index) back to the owning requester.
- Handles early decoder errors by draining the rest of the document, and decoder hangs by timeout and abort.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IDX_W, 16, width of the error byte index.
- TIMEOUT, 1024, cycles to wait for a decoder result after the last byte (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- req_valid  in  N_REQ  per-requester byte valid.
- req_ready  out  N_REQ  per-requester byte accept.
- req_data  in  N_REQ*8  per-requester byte, packed, requester i at [8i+7:8i].
- req_last  in  N_REQ  marks the final byte of a document.
- dec_valid  out  1  byte to the decoder.
- dec_ready  in  1  decoder accepts the byte.
- dec_data  out  8  byte to the decoder.
- dec_last  out  1  last byte to the decoder.
- dec_abort  out  1  one-cycle pulse that resets the decoder document state.
- dec_done  in  1  one-cycle result strobe from the decoder.
- dec_ok  in  1  result is success.
- dec_err_kind  in  ERR_KIND_W  error kind code.
- dec_err_idx  in  IDX_W  index of the offending byte.
- rsp_valid  out  N_REQ  one-hot; result pending for requester i.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_ok  out  1  shared result field.
- rsp_err_kind  out  ERR_KIND_W  shared result field.
- rsp_err_idx  out  IDX_W  shared result field.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; rr_ptr = 0; owner = 0; result registers 0; timeout counter 0.
- States: IDLE, STREAM, DRAIN, WAIT_RSP, RSP.
- IDLE:
  - Round-robin pick of the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - The winner is registered as owner and the FSM moves to STREAM.
  - No byte is accepted in the pick cycle, so there is 1 cycle of grant latency.
- STREAM:
  - Combinational pass-through: dec_valid = req_valid[owner]; dec_data/dec_last from owner; req_ready[owner] = dec_ready; all other req_ready = 0.
  - A byte transfers when dec_valid && dec_ready.
  - Transfer with req_last: go to WAIT_RSP and clear the timeout counter.
  - dec_done without that transfer: latch the result.
    - If a req_last transfer does not occur in this same cycle, go to DRAIN (early error).
    - If it does, go directly to RSP.
- DRAIN:
  - dec_valid = 0; req_ready[owner] = 1; bytes are discarded.
  - On the owner's req_last handshake: go to RSP.
- WAIT_RSP:
  - Counter increments each cycle.
  - dec_done: latch the result and go to RSP.
  - Counter reaches TIMEOUT-1 without dec_done:
    - latch rsp_ok = 0, rsp_err_kind = ERR_ARB_TIMEOUT, rsp_err_idx = all-ones;
    - pulse dec_abort for 1 cycle;
    - go to RSP.
  - dec_done in the same cycle as the timeout: dec_done wins and there is no abort.
- RSP:
  - rsp_valid[owner] = 1; shared fields hold the latched values until rsp_ready[owner].
  - On the handshake: rr_ptr = (owner+1) mod N_REQ; go to IDLE.
  - A new grant therefore starts 1 cycle after the handshake.
- dec_done outside STREAM/WAIT_RSP is ignored.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0; a partially sent document is lost; dec_abort is not pulsed.
- rsp_* fields are driven 0 when rsp_valid is all-zero.

Decomposition:
- Package json_hw_pkg holds:
  - ERR_KIND_W = 4;
  - error kind localparams mirroring the software json_error kinds, plus ERR_ARB_TIMEOUT = 4'hF;
  - the state enum typedef;
  - the dec_result_t packed struct {ok, kind, idx}.
- Sub-module rr_picker(N):
  - inputs: req vector and pointer;
  - outputs: grant index and any-valid;
  - purely combinational.

Test Plan:
- Reset then req0 sends "[1]" (3 bytes, last on ']'); dec_done ok 2 cycles after last → rsp_valid = 4'b0001, rsp_ok = 1; rr_ptr = 1 after rsp_ready.
- req0, req2 and req3 all valid at once; each sends a 2-byte doc → grant order 0, 2, 3; no interleaving of bytes on dec_data; req_ready for non-owners is 0 throughout.
- req1 sends a 6-byte doc; decoder raises dec_done err kind 3, idx 2 after byte 3 → remaining 3 bytes are drained with dec_valid = 0; rsp gives kind 3, idx 2, ok = 0.
- TIMEOUT = 8; req0 sends "{}" and the decoder stays silent → exactly 8 cycles after the last byte, dec_abort pulses once; rsp kind 4'hF, idx 16'hFFFF.
- dec_ready toggles 1/0 every cycle during a 4-byte doc → all 4 bytes arrive in order; no duplicates, no drops.
- rst asserted mid-STREAM after 2 of 5 bytes → outputs 0 immediately; after release, req3 is granted first when it is the only one valid.
